wb_slave_splitter: RTL

Parametrised Wishbone classic slave-side splitter that sits between the Caravel user-area Wishbone port and NUM_SLAVES peripheral slaves inside the FPGA user project wrapper. It decodes an address field to pick one slave and forwards the strobe to it. It registers the slave's acknowledge and read data back to the master. With the timeout feature compiled in, it returns a default word when a slave is unmapped or never acknowledges.

---
 rtl/wb_slave_splitter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/wb_slave_splitter.sv
// wb_slave_splitter
// Wishbone classic slave-side splitter. It decodes wbs_adr_i[SEL_LSB +: SEL_W]
// to pick one of NUM_SLAVES downstream slaves and strobes that slave. The
// slave's acknowledge and read data go back to the master through registers.
//
// Optional feature: define WB_SPLIT_TIMEOUT_EN to build the BUSY-state
// watchdog. When it is defined, a slave that never acks is forced to complete
// with DEFAULT_DATA, and timeout_o / timeout_cnt_o report those completions.
// When it is undefined, BUSY waits indefinitely and both outputs read 0.
// Unmapped slave indices always complete with DEFAULT_DATA.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, async active-high reset
//   wbs_cyc/stb/we/sel/adr/dat  master request
//   wbs_ack_o, wbs_dat_o        registered response to the master
//   s_cyc_o, s_stb_o            shared cycle, one-hot strobe to the slaves
//   s_we/sel/adr/dat_o          combinational broadcast of the master request
//   s_ack_i, s_dat_i            per-slave ack and read data (slave k at [32k+:32])
//   timeout_o                   one-cycle pulse on a forced completion
//   timeout_cnt_o               saturating count of forced completions
//
// state | meaning
// IDLE  | wait for cyc&stb, latch slave index
// BUSY  | strobe selected slave, wait for its ack (or the watchdog)
// RESP  | one-cycle ack to the master with the captured word

module wb_slave_splitter #(
  parameter int          NUM_SLAVES   = 4,
  parameter int          SEL_LSB      = 14,
  parameter int          SEL_W        = $clog2(NUM_SLAVES),
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] DEFAULT_DATA = 32'hDEADBEEF
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic                     s_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_stb_o,
  output logic                     s_we_o,
  output logic [3:0]               s_sel_o,
  output logic [31:0]              s_adr_o,
  output logic [31:0]              s_dat_o,
  input  logic [NUM_SLAVES-1:0]    s_ack_i,
  input  logic [32*NUM_SLAVES-1:0] s_dat_i,
  output logic                     timeout_o,
  output logic [7:0]               timeout_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // One extra bit so a non-power-of-two slave count compares correctly.
  localparam logic [SEL_W:0] NUM_S = (SEL_W+1)'(NUM_SLAVES);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [31:0]      dat_q, dat_d;
  logic [SEL_W-1:0] adr_idx;
  logic             mapped;
  logic             ack_sel;
  logic [31:0]      dat_sel;
  logic             tmo_fire;

  assign adr_idx = wbs_adr_i[SEL_LSB +: SEL_W];
  assign mapped  = ({1'b0, adr_idx} < NUM_S);

  assign s_we_o  = wbs_we_i;
  assign s_sel_o = wbs_sel_i;
  assign s_adr_o = wbs_adr_i;
  assign s_dat_o = wbs_dat_i;

  // Only the latched slave's ack and data are visible to the FSM.
  always_comb begin
    ack_sel = 1'b0;
    dat_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == SEL_W'(k)) begin
        ack_sel = s_ack_i[k];
        dat_sel = s_dat_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    s_stb_o = '0;
    if (state_q == ST_BUSY) begin
      for (int k = 0; k < NUM_SLAVES; k++) begin
        s_stb_o[k] = (idx_q == SEL_W'(k));
      end
    end
  end

  assign s_cyc_o   = (state_q == ST_BUSY);
  assign wbs_ack_o = (state_q == ST_RESP);
  assign wbs_dat_o = dat_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dat_d   = dat_q;
    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          idx_d = adr_idx;
          if (mapped) begin
            state_d = ST_BUSY;
          end else begin
            dat_d   = DEFAULT_DATA;
            state_d = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        // Abort beats ack; ack beats the watchdog.
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (ack_sel) begin
          dat_d   = dat_sel;
          state_d = ST_RESP;
        end else if (tmo_fire) begin
          dat_d   = DEFAULT_DATA;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dat_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dat_q   <= dat_d;
    end
  end

`ifdef WB_SPLIT_TIMEOUT_EN
  // Down-counter armed with TIMEOUT-1 on BUSY entry; reaching zero with no
  // ack is the same cycle as an up-count hitting TIMEOUT-1.
  localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT - 1);

  logic [15:0] tmr_q;
  logic [7:0]  tcnt_q;

  assign tmo_fire = (state_q == ST_BUSY) && wbs_cyc_i && !ack_sel && (tmr_q == 16'd0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmr_q <= 16'd0;
    end else if (state_q == ST_IDLE && state_d == ST_BUSY) begin
      tmr_q <= TMR_LOAD;
    end else if (state_q == ST_BUSY && state_d == ST_BUSY) begin
      tmr_q <= tmr_q - 16'd1;
    end else begin
      tmr_q <= 16'd0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tcnt_q <= 8'd0;
    end else if (tmo_fire && tcnt_q != 8'hFF) begin
      tcnt_q <= tcnt_q + 8'd1;
    end
  end

  assign timeout_o     = tmo_fire;
  assign timeout_cnt_o = tcnt_q;
`else
  // TIMEOUT has no effect without the watchdog.
  localparam logic [15:0] TMO_PARAM = 16'(TIMEOUT);
  logic unused_timeout;
  assign unused_timeout = ^TMO_PARAM;

  assign tmo_fire      = 1'b0;
  assign timeout_o     = 1'b0;
  assign timeout_cnt_o = 8'd0;
`endif

endmodule
